// File: rtl/hermitian_qam_framer.sv
`default_nettype none
// ============================================================================
// Module   : hermitian_qam_framer
// Purpose  : Packs an MSB-first byte stream into QPSK/16-QAM/64-QAM carrier
//            indices for carriers 1..N-1. It then emits a 2N-sample frame
//            with Hermitian symmetry, so that an IFFT of the frame yields a
//            real-valued signal.
// Ports    : aclk, reset_n          - clock, asynchronous active-low reset
//            mode, carrier_mask     - constellation and carrier enables,
//                                     both latched once per frame
//            s_tdata/s_tvalid/s_tready         - byte input stream
//            m_tdata/m_tvalid/m_tready/m_tlast - {re,im} sample output stream
//            frame_done             - pulses on the final sample handshake
// Revision : 1.0 - initial release
// ============================================================================
module hermitian_qam_framer #(
    parameter int B = 8,
    parameter int N = 8
) (
    input  logic         aclk,
    input  logic         reset_n,
    input  logic [1:0]   mode,
    input  logic [N-1:0] carrier_mask,
    input  logic [B-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [31:0]  m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         m_tlast,
    output logic         frame_done
);

    localparam int c_ACC_W = B + 5;
    localparam int c_CW    = $clog2(B + 6);
    localparam int c_NW    = $clog2(N);
    localparam int c_IW    = $clog2(2 * N);

    localparam logic [c_IW-1:0] c_LAST = c_IW'(2 * N - 1);
    localparam logic [N-1:0]    c_ONE  = {{(N-1){1'b0}}, 1'b1};

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               r_latched;      // mode/mask captured for this frame
    logic [1:0]         r_mode;
    logic [N-1:0]       r_mask;
    logic [N-1:0]       r_pend;         // enabled carriers not yet filled
    logic [c_ACC_W-1:0] r_acc;          // left-aligned; valid bits at the top
    logic [c_CW-1:0]    r_cnt;
    logic [c_IW-1:0]    r_idx;
    logic [31:0]        r_tdata;
    logic               r_tvalid;
    logic               r_tlast;
    logic [5:0]         r_buf [N];

    logic [c_CW-1:0]    w_k;
    logic               w_have_k;
    logic               w_loading;
    logic               w_pend_any;
    logic               w_accept;
    logic               w_write;
    logic               w_last_write;
    logic               w_hs;
    logic [N-1:0]       w_first;
    logic [c_NW-1:0]    w_slot;
    logic [5:0]         w_top;
    logic [5:0]         w_sym_in;
    logic [c_ACC_W-1:0] w_in_al;

    logic [c_IW-1:0]    w_nidx;
    logic               w_conj;
    logic [c_NW-1:0]    w_car;
    logic [5:0]         w_sym;
    logic [2:0]         w_vi;
    logic [2:0]         w_vq;
    logic [15:0]        w_re;
    logic [15:0]        w_im_raw;
    logic [15:0]        w_im;
    logic [31:0]        w_sample;

    // Axis level (2v-(L-1))*STEP; the largest magnitude is 32736, so the
    // imaginary part can always be negated without overflow.
    function automatic logic [15:0] f_level(input logic [2:0] v, input logic [1:0] md);
        int t;
        case (md)
            2'd1:    t = (2 * int'(v) - 3) * 10912;
            2'd2:    t = (2 * int'(v) - 7) * 4676;
            default: t = (2 * int'(v) - 1) * 32736;
        endcase
        return 16'(t);
    endfunction

    always_comb begin
        case (r_mode)
            2'd1:    w_k = c_CW'(4);
            2'd2:    w_k = c_CW'(6);
            default: w_k = c_CW'(2);
        endcase
    end

    assign w_have_k   = (r_cnt >= w_k);
    assign w_loading  = (r_state == S_LOAD) && r_latched;
    assign w_pend_any = |r_pend;
    assign s_tready   = w_loading && !w_have_k && w_pend_any;
    assign w_accept   = s_tready && s_tvalid;
    assign w_write    = w_loading && w_have_k && w_pend_any;

    // The lowest pending carrier is the next one to fill.
    assign w_first      = r_pend & (~r_pend + c_ONE);
    assign w_last_write = w_write && ((r_pend & ~w_first) == '0);

    always_comb begin
        w_slot = '0;
        for (int i = N - 1; i >= 1; i--) begin
            if (r_pend[i]) w_slot = c_NW'(i);
        end
    end

    // Incoming bytes are placed directly below the bits already held.
    assign w_in_al = {s_tdata, 5'b00000};
    assign w_top   = r_acc[c_ACC_W-1 -: 6];

    always_comb begin
        case (r_mode)
            2'd1:    w_sym_in = {2'b00, w_top[5:2]};
            2'd2:    w_sym_in = w_top;
            default: w_sym_in = {4'b0000, w_top[5:4]};
        endcase
    end

    assign w_hs       = (r_state == S_EMIT) && r_tvalid && m_tready;
    assign frame_done = w_hs && r_tlast;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                if (r_latched && (!w_pend_any || w_last_write)) w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (w_hs && r_tlast) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Next sample. For k >= N the source carrier is 2N-k. With N a power of
    // two, 2N-k is the negation of the low index bits, and both k=0 and k=N
    // land on carrier 0, which is never enabled.
    always_comb begin
        w_nidx   = r_idx + c_IW'(1);
        w_conj   = w_nidx[c_IW-1];
        w_car    = w_conj ? ({c_NW{1'b0}} - w_nidx[c_NW-1:0]) : w_nidx[c_NW-1:0];
        w_sym    = r_buf[w_car];
        case (r_mode)
            2'd1: begin
                w_vi = {1'b0, w_sym[3:2]};
                w_vq = {1'b0, w_sym[1:0]};
            end
            2'd2: begin
                w_vi = w_sym[5:3];
                w_vq = w_sym[2:0];
            end
            default: begin
                w_vi = {2'b00, w_sym[1]};
                w_vq = {2'b00, w_sym[0]};
            end
        endcase
        w_re     = f_level(w_vi, r_mode);
        w_im_raw = f_level(w_vq, r_mode);
        w_im     = w_conj ? (16'd0 - w_im_raw) : w_im_raw;
        w_sample = 32'h0000_0000;
        if ((w_car != '0) && r_mask[w_car]) w_sample = {w_re, w_im};
    end

    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_LOAD;
            r_latched <= 1'b0;
            r_mode    <= 2'd0;
            r_mask    <= '0;
            r_pend    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_tdata   <= 32'h0000_0000;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // The first LOAD cycle of every frame captures the configuration.
            if ((r_state == S_LOAD) && !r_latched) begin
                r_latched <= 1'b1;
                r_mode    <= mode;
                r_mask    <= carrier_mask;
                r_pend    <= carrier_mask & ~c_ONE;
            end

            // Accept and write never coincide: s_tready requires fewer than
            // K bits, and a write requires at least K.
            if (w_accept) begin
                r_acc <= r_acc | (w_in_al >> r_cnt);
                r_cnt <= r_cnt + c_CW'(B);
            end
            if (w_write) begin
                r_acc  <= r_acc << w_k;
                r_cnt  <= r_cnt - w_k;
                r_pend <= r_pend & ~w_first;
            end

            if ((r_state == S_LOAD) && (w_state_nxt == S_EMIT)) begin
                r_idx    <= '0;
                r_tdata  <= 32'h0000_0000;
                r_tvalid <= 1'b1;
                r_tlast  <= 1'b0;
            end

            if (w_hs) begin
                if (r_tlast) begin
                    r_idx     <= '0;
                    r_tdata   <= 32'h0000_0000;
                    r_tvalid  <= 1'b0;
                    r_tlast   <= 1'b0;
                    r_latched <= 1'b0;
                end else begin
                    r_idx   <= w_nidx;
                    r_tdata <= w_sample;
                    r_tlast <= (w_nidx == c_LAST);
                end
            end
        end
    end

    // Carrier index storage. Stale entries are harmless because disabled
    // carriers are forced to zero on output.
    always_ff @(posedge aclk) begin
        if (w_write) r_buf[w_slot] <= w_sym_in;
    end

    assign m_tdata  = r_tdata;
    assign m_tvalid = r_tvalid;
    assign m_tlast  = r_tlast;

endmodule
`default_nettype wire

// File: doc/hermitian_qam_framer.md
HERMITIAN_QAM_FRAMER -- requirements
Module: hermitian_qam_framer

Interface
REQ-001 Parameter B, default 8, is the input byte width in bits and SHALL be 4..16.
REQ-002 Parameter N, default 8, is the half-frame carrier count; it SHALL be a power of 2 from 4 to 256, and the frame length SHALL be 2N samples.
REQ-003 Port aclk, input, 1 bit: the only clock; all logic SHALL be on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port mode, input, 2 bits: 0 = QPSK (K=2 bits/carrier), 1 = 16-QAM (K=4), 2 = 64-QAM (K=6), 3 = reserved and treated as QPSK.
REQ-006 Port carrier_mask, input, N bits: bit k enables carrier k; bit 0 is ignored.
REQ-007 Port s_tdata, input, B bits: payload byte, consumed MSB-first.
REQ-008 Port s_tvalid, input, 1 bit: upstream data valid.
REQ-009 Port s_tready, output, 1 bit: block accepts s_tdata.
REQ-010 Port m_tdata, output, 32 bits: sample as {re[15:0], im[15:0]}, each half two's complement.
REQ-011 Port m_tvalid, output, 1 bit: sample valid.
REQ-012 Port m_tready, input, 1 bit: downstream accepts the sample.
REQ-013 Port m_tlast, output, 1 bit: asserted with sample 2N-1.
REQ-014 Port frame_done, output, 1 bit: one-cycle pulse on the cycle the last sample of a frame handshakes.

Function
REQ-015 The block SHALL be a two-state FSM, LOAD -> EMIT -> LOAD, starting in LOAD after reset.
REQ-016 On entering LOAD, mode and carrier_mask SHALL be latched, and the latched values SHALL hold for the whole frame; input changes mid-frame SHALL have no effect until the next frame.
REQ-017 A bit accumulator, B+5 bits wide, SHALL hold unconsumed bits.
REQ-018 In LOAD, s_tready SHALL be 1 only while the accumulator holds fewer than K bits and at least one enabled carrier remains unfilled.
REQ-019 A byte SHALL be accepted only when s_tvalid and s_tready are both 1, and its bits SHALL be appended below the existing accumulator bits.
REQ-020 Whenever the accumulator holds at least K bits, the top K bits SHALL be written to the buffer entry of the next enabled carrier in ascending order 1..N-1, at one carrier per cycle.
REQ-021 Disabled carriers SHALL consume no bits.
REQ-022 Bits left over after a frame's last enabled carrier SHALL remain in the accumulator and SHALL be the first bits of the next frame, even if mode changes.
REQ-023 If no carrier in 1..N-1 is enabled, LOAD SHALL proceed directly to EMIT and consume no input.
REQ-024 EMIT SHALL begin on the cycle after the last enabled carrier is written; s_tready SHALL be 0 throughout EMIT.
REQ-025 EMIT SHALL output samples k = 0..2N-1 in order, one per m_tvalid&&m_tready handshake.
REQ-026 Samples k=0 and k=N, and every disabled carrier, SHALL be 0x00000000.
REQ-027 For 1<=k<N, the sample SHALL be the map of X[k].
REQ-028 For N<k<2N, the sample SHALL be {re of X[2N-k], -(im of X[2N-k])}, i.e. Hermitian symmetry.
REQ-029 Mapping: the upper K/2 bits of the K-bit index SHALL give the I value v, and the lower K/2 bits SHALL give the Q value.
REQ-030 Each axis level SHALL be (2v-(L-1))*STEP, with L=2^(K/2) and STEP = 32736 for QPSK, 10912 for 16-QAM and 4676 for 64-QAM; no level SHALL equal -32768, so negation never overflows.
REQ-031 m_tdata and m_tlast SHALL be registered and SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-032 m_tvalid SHALL stay 1 across EMIT until the final handshake.
REQ-033 m_tvalid SHALL rise on the first EMIT cycle, with no bubbles between samples while m_tready=1.
REQ-034 After the handshake of sample 2N-1, frame_done SHALL pulse and the FSM SHALL return to LOAD on the next cycle, with m_tvalid=0.
REQ-035 m_tready=1 outside EMIT SHALL have no effect.
REQ-036 s_tvalid dropping mid-LOAD SHALL stall loading without loss of bits.

Reset
REQ-037 While reset_n=0: the FSM SHALL be in LOAD, the accumulator SHALL be empty, and the carrier pointer and sample index SHALL be 0.
REQ-038 While reset_n=0: s_tready, m_tvalid, m_tlast and frame_done SHALL be 0, and m_tdata SHALL be 0x00000000.
REQ-039 Reset asserted mid-LOAD or mid-EMIT SHALL abort the frame and discard the accumulator; no partial frame SHALL be emitted after release.
REQ-040 After release, s_tready SHALL rise no earlier than the first rising edge.

Verification
REQ-041 QPSK, N=8, mask 0xFE, bytes 0x1B then 0xE4, m_tready=1 -> k1=0x80208020, k2=0x80207FE0, k3=0x7FE08020, k15=0x80207FE0, k0=k8=0, and m_tlast on k15; 2 leftover bits (00) are retained.
REQ-042 16-QAM, mask 0x06, bytes 0xF0 then 0x5A -> k1=0x7FE07FE0, k2=0x80208020, k14=0x80207FE0, k3..k7=0 and k9..k13=0, and the leftover 0x5A is retained for the next frame.
REQ-043 64-QAM, mask 0x02, byte 0xE0 (bits 111000) -> k1=0x7FDC8024, k15=0x7FDC7FDC, and 2 leftover bits are retained.
REQ-044 m_tready low for 3 cycles while sample 5 is valid -> m_tdata, m_tvalid and m_tlast are held, no sample is skipped, and frame_done pulses exactly once.
REQ-045 Mask 0x00 -> 16 zero samples, s_tready stays 0, and an input byte is still pending afterwards; mode changed mid-EMIT takes effect only in the next frame.
REQ-046 reset_n pulsed low at EMIT sample 7 -> all outputs 0 during reset, and the next frame loads fresh with no leftover bits.
